// File: rtl/output_writeback_pkg.sv
// Shared types and width helpers for the convolution core output writeback stage.
package output_writeback_pkg;

  typedef struct packed {
    int unsigned DATA_WIDTH;
    int unsigned FEATURE_MAP_WIDTH;
    int unsigned FEATURE_MAP_HEIGHT;
    int unsigned OUTPUT_NB_CHANNELS;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    DATA_WIDTH:         16,
    FEATURE_MAP_WIDTH:  4,
    FEATURE_MAP_HEIGHT: 4,
    OUTPUT_NB_CHANNELS: 2
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int total_results(input config_t c);
    return int'(c.FEATURE_MAP_WIDTH * c.FEATURE_MAP_HEIGHT * c.OUTPUT_NB_CHANNELS);
  endfunction

  function automatic int coord_width(input int n);
    return clog2_min1(n);
  endfunction

  function automatic int addr_width(input config_t c);
    return clog2_min1(total_results(c));
  endfunction

  function automatic int count_width(input config_t c);
    return $clog2(total_results(c) + 1);
  endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Output-memory write port: valid/ready handshake carrying a flat address and a result.
interface output_writeback_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_valid;
  logic                     wr_ready;

  modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/output_writeback_wb_fifo.sv
// Synchronous FIFO with flush; the head entry is held in a register so the read side is glitch-free.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i) level_d = level_q + 1'b1;
      else if (!push_i && pop_i) level_d = level_q - 1'b1;
      // Head register mirrors whichever entry sits at the read pointer after this cycle.
      if (pop_i) begin
        if (level_q > LVL_W'(1)) dout_d = mem_q[rd_ptr_d];
        else if (push_i)         dout_d = din_i;
      end else if (level_q == '0 && push_i) begin
        dout_d = din_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= (level_d != '0);
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/output_writeback.sv
// Writeback stage: range-checks and optionally ReLUs the core output stream, flattens
// coordinates to a channel-major address and drains results through a FIFO to memory.
module output_writeback
  import output_writeback_pkg::*;
#(
  parameter config_t CFG        = DEFAULT_CFG,
  parameter int      FIFO_DEPTH = 4,
  parameter bit      RELU       = 1'b0,
  localparam int DATA_W = int'(CFG.DATA_WIDTH),
  localparam int X_W    = coord_width(int'(CFG.FEATURE_MAP_WIDTH)),
  localparam int Y_W    = coord_width(int'(CFG.FEATURE_MAP_HEIGHT)),
  localparam int CH_W   = coord_width(int'(CFG.OUTPUT_NB_CHANNELS)),
  localparam int ADDR_W = addr_width(CFG),
  localparam int CNT_W  = count_width(CFG)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic [X_W-1:0]           in_x_i,
  input  logic [Y_W-1:0]           in_y_i,
  input  logic [CH_W-1:0]          in_ch_i,
  output_writeback_if.master       wr,
  output logic [CNT_W-1:0]         count_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic                     coord_err_o
);
  localparam int W       = int'(CFG.FEATURE_MAP_WIDTH);
  localparam int H       = int'(CFG.FEATURE_MAP_HEIGHT);
  localparam int C       = int'(CFG.OUTPUT_NB_CHANNELS);
  localparam int TOTAL   = total_results(CFG);
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  wb_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               coord_err_q, coord_err_d;
  logic               accept, in_range, push, pop, next_empty;
  logic [ADDR_W-1:0]  addr_calc;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_valid, fifo_full, fifo_empty;
  logic [LVL_W-1:0]   fifo_level;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] d);
    if (RELU && d[DATA_W-1]) return '0;
    return d;
  endfunction

  always_comb begin
    in_range   = (int'(in_x_i) < W) && (int'(in_y_i) < H) && (int'(in_ch_i) < C);
    accept     = (state_q == ST_RUN) && in_valid_i && !start_i;
    pop        = fifo_valid && wr.wr_ready;
    push       = accept && in_range && (!fifo_full || pop);
    // Operands widened to the full address width first so ch*H*W cannot wrap.
    addr_calc  = (ADDR_W'(in_ch_i) * ADDR_W'(H) + ADDR_W'(in_y_i)) * ADDR_W'(W)
                 + ADDR_W'(in_x_i);
    fifo_din   = {addr_calc, relu(in_data_i)};
    next_empty = (fifo_empty && !push) || ((fifo_level == LVL_W'(1)) && pop && !push);
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    coord_err_d = coord_err_q;
    if (start_i) begin
      state_d     = ST_RUN;
      count_d     = '0;
      overflow_d  = 1'b0;
      coord_err_d = 1'b0;
    end else begin
      if (pop && count_q != CNT_W'(TOTAL)) count_d = count_q + 1'b1;
      if (accept && !in_range) coord_err_d = 1'b1;
      if (accept && in_range && fifo_full && !pop) overflow_d = 1'b1;
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (count_d == CNT_W'(TOTAL) && next_empty) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      coord_err_q <= coord_err_d;
    end
  end

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .flush_i (start_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign wr.wr_valid = fifo_valid;
  assign wr.wr_addr  = fifo_dout[ENTRY_W-1:DATA_W];
  assign wr.wr_data  = fifo_dout[DATA_W-1:0];
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign coord_err_o = coord_err_q;
endmodule

// File: doc/output_writeback.md
# output_writeback

Downstream stage of the convolution core: captures the unhandshaked output stream (data plus x/y/channel coordinates), applies optional ReLU, and converts coordinates to a flat channel-major address. Buffers results in a small FIFO and drains them to the output-memory write port over a valid/ready handshake. Counts written results and flags completion of a full output feature map, plus sticky error conditions.

## Interface
- cfg, config_t from the shared package: DATA_WIDTH, FEATURE_MAP_WIDTH (W), FEATURE_MAP_HEIGHT (H), OUTPUT_NB_CHANNELS (C)
- FIFO_DEPTH, 4: result buffer entries; power of two, ≥2
- RELU, 0: 1 clamps negative results to 0 before buffering
- clk  in  1  sole clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new feature map; clears state
- in_data  in  DATA_WIDTH  signed result, driven from core output_data
- in_valid  in  1  result present this cycle; no back-pressure exists
- in_x  in  $clog2(W)  column
- in_y  in  $clog2(H)  row
- in_ch  in  $clog2(C)  output channel
- wr_addr  out  $clog2(W*H*C)  flat address (ch*H + y)*W + x
- wr_data  out  DATA_WIDTH  result
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts
- count  out  $clog2(W*H*C+1)  results written since start
- done  out  1  all W*H*C results written
- overflow  out  1  sticky: result dropped, FIFO full
- coord_err  out  1  sticky: coordinate out of range

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. start → RUN from any state. RUN → DONE when count == W*H*C and FIFO empty. DONE holds until start.
- in_valid ignored in IDLE and DONE.
- RUN, in_valid: if in_x ≥ W, in_y ≥ H or in_ch ≥ C → drop, set coord_err. Else if FIFO full and no pop this cycle → drop, set overflow. Else push {addr, data}.
- Address computed at push in full address width; no truncation of intermediate products.
- ReLU: with RELU=1, in_data MSB set → push 0.
- Pop occurs when wr_valid && wr_ready; count increments by 1 per pop, saturating at W*H*C.
- start mid-operation: FIFO flushed (entries discarded, not written), count, overflow, coord_err cleared. An in_valid coincident with start is ignored.
- Full with simultaneous push and pop: both occur, occupancy unchanged, no overflow.

## Timing
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, count 0, done 0, overflow 0, coord_err 0; state IDLE, FIFO empty.
- All outputs registered.
- Latency: result pushed in cycle N appears on wr_valid/wr_addr/wr_data in cycle N+1 at earliest (FIFO empty, no write pending).
- Handshake: once asserted, wr_valid stays high and wr_addr/wr_data stay stable until wr_ready is sampled high; wr_valid may not depend combinationally on wr_ready.
- Sustained throughput: one result per cycle with wr_ready held high; no bubbles.
- done rises the cycle after the final pop; count updates the cycle after each pop.
- overflow and coord_err set the cycle after the offending in_valid.
- Reset asserted mid-transfer: outputs return to reset values immediately, asynchronously.

## Structure
- Shared package: config_t (already present), helpers for address and count widths, state enum for IDLE/RUN/DONE.
- One sub-module: wb_fifo — synchronous FIFO, parameterized width and depth, with push, pop, full, empty, and flush; registered head output.
- Top level contains the FSM, range check, ReLU, address arithmetic, counter, and sticky flags.

## Test plan
- W=H=4, C=2, DATA_WIDTH=16, wr_ready=1; start, then 32 in_valid pulses in raster order → 32 writes, addresses 0..31 in order, done high the cycle after the last pop, count=32.
- Result in_x=3, in_y=2, in_ch=1, data=-5; RELU=0 → wr_addr=27, wr_data=-5; RELU=1 → wr_data=0.
- FIFO_DEPTH=4, wr_ready=0, 6 consecutive results → first 4 held, overflow=1 after the 5th; release wr_ready → exactly 4 writes, count=4.
- FIFO full, wr_ready=1, in_valid=1 on the same cycle → push accepted, overflow stays 0, wr_data stable across earlier stalled cycles.
- C=3 (in_ch 2 bits), in_ch=3 → no write, coord_err=1; then start → coord_err=0, count=0, FIFO empty.
- start pulse while 3 entries are buffered and wr_ready=0 → wr_valid drops the next cycle, none of the 3 are written, state RUN.
